// File: rtl/seg_pipe_accumulator_if.sv
// Run/stream interface of seg_pipe_accumulator.
//   master drives : start, len, in_valid, in_data
//   slave drives  : in_ready, busy, done, result, overflow
interface seg_pipe_accumulator_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned COUNT_W = 9
) ();
  logic               start;
  logic [COUNT_W-1:0] len;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data;
  logic               busy;
  logic               done;
  logic [ACC_W-1:0]   result;
  logic               overflow;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, busy, done, result, overflow
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, busy, done, result, overflow
  );
endinterface

// File: rtl/seg_pipe_accumulator.sv
// Streaming accumulator: sums len input words into an ACC_W-bit total using
// SEGS carry-pipelined adder segments, then flushes the carries and reports.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        seg_pipe_accumulator_if.slave
//              start/len    run request (len sampled with start)
//              in_valid/in_ready/in_data  word stream
//              busy, done, result, overflow  status and registered result
module seg_pipe_accumulator #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned SEGS    = 2,
  parameter int unsigned COUNT_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_pipe_accumulator_if.slave bus
);
  localparam int unsigned SEG_W = ACC_W / SEGS;
  localparam int unsigned SUM_W = SEG_W + 1;
  localparam int unsigned FL_W  = (SEGS > 1) ? $clog2(SEGS) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(SEGS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_FLUSH, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [FL_W-1:0]    fl_q, fl_d;
  logic [SEG_W-1:0]   seg_q [SEGS];
  logic [SEG_W-1:0]   seg_d [SEGS];
  // carry_q[k] is the registered carry into segment k; bit 0 stays 0
  logic [SEGS-1:0]    carry_q, carry_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [ACC_W-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;

  logic               beat_c;
  logic [ACC_W-1:0]   data_ext_c;
  logic [SEG_W-1:0]   seg_in_c [SEGS];
  logic [SUM_W-1:0]   sum_c [SEGS];
  logic               top_carry_c;

  assign bus.in_ready = in_ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.overflow = overflow_q;

  // Per-segment adders: one SEG_W-bit add each, carries taken from registers
  always_comb begin
    beat_c     = bus.in_valid && in_ready_q;
    data_ext_c = ACC_W'(bus.in_data);
    for (int unsigned k = 0; k < SEGS; k++) begin
      seg_in_c[k] = beat_c ? data_ext_c[k*SEG_W +: SEG_W] : '0;
      sum_c[k]    = SUM_W'(seg_q[k]) + SUM_W'(seg_in_c[k]) + SUM_W'(carry_q[k]);
    end
    top_carry_c = sum_c[SEGS-1][SEG_W];
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fl_d       = fl_q;
    carry_d    = carry_q;
    ovf_acc_d  = ovf_acc_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    for (int unsigned k = 0; k < SEGS; k++) seg_d[k] = seg_q[k];

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          cnt_d      = COUNT_W'(bus.len);
          fl_d       = '0;
          carry_d    = '0;
          ovf_acc_d  = 1'b0;
          overflow_d = 1'b0;
          for (int unsigned k = 0; k < SEGS; k++) seg_d[k] = '0;
          if (bus.len != '0) begin
            state_d = S_ACCUM;
          end else begin
            state_d  = S_DONE;
            result_d = '0;
          end
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end

      S_ACCUM, S_FLUSH: begin
        carry_d[0] = 1'b0;
        for (int unsigned k = 0; k < SEGS; k++) begin
          seg_d[k] = sum_c[k][SEG_W-1:0];
          if (k + 1 < SEGS) carry_d[k+1] = sum_c[k][SEG_W];
        end
        ovf_acc_d = ovf_acc_q | top_carry_c;

        if (state_q == S_ACCUM) begin
          if (beat_c) begin
            cnt_d = cnt_q - COUNT_W'(1);
            if (cnt_q == COUNT_W'(1)) begin
              state_d = S_FLUSH;
              fl_d    = '0;
            end
          end
        end else if (fl_q == FL_LAST) begin
          // carries are all zero by now, so the segments hold the final sum
          result_d = '0;
          for (int unsigned k = 0; k < SEGS; k++) result_d[k*SEG_W +: SEG_W] = sum_c[k][SEG_W-1:0];
          overflow_d = ovf_acc_d;
          state_d    = S_DONE;
        end else begin
          fl_d = fl_q + FL_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    done_d     = (state_d == S_DONE);
    busy_d     = (state_d == S_ACCUM) || (state_d == S_FLUSH);
    in_ready_d = (state_d == S_ACCUM);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fl_q       <= '0;
      carry_q    <= '0;
      ovf_acc_q  <= 1'b0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      for (int unsigned k = 0; k < SEGS; k++) seg_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fl_q       <= fl_d;
      carry_q    <= carry_d;
      ovf_acc_q  <= ovf_acc_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      for (int unsigned k = 0; k < SEGS; k++) seg_q[k] <= seg_d[k];
    end
  end
endmodule
